irq_controller: RTL



---
 rtl/irq_pkg.sv | 8 +
 rtl/irq_sync_edge.sv | 22 ++
 rtl/irq_controller.sv | 65 ++++++
 3 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM encoding and mcause constants for the interrupt controller
package irq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE, RET} irq_state_t;
  localparam int IRQ_MAX = 16;
  localparam int ID_W = $clog2(IRQ_MAX);
  localparam int IRQ_CAUSE_BASE = 16;
  localparam logic [31:0] IRQ_CAUSE_INT = 32'h8000_0000;
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: multi-flop synchroniser followed by rising-edge detect for one line
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic edge_o
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end
  assign edge_o = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: sticky edge-pending bits, fixed-priority selection (lowest index wins)
// and a request/service/return sequencer towards the core trap logic.
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             irq_ack_i,
  input  logic             irq_ret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic [N_IRQ-1:0] irq_pending_o
);
  irq_state_t       r_state;
  logic [ID_W-1:0]  r_id, w_win;
  logic [N_IRQ-1:0] r_pend, w_edge, w_cand, w_id_oh, w_clr;
  logic [31:0]      r_cause;
  for (genvar i = 0; i < N_IRQ; i++) begin : g_line
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .async_i(irq_i[i]),
      .edge_o (w_edge[i])
    );
  end
  assign w_cand  = r_pend & mie_i;
  assign w_id_oh = N_IRQ'(1) << r_id;
  assign w_clr   = (r_state == REQ && irq_ack_i) ? w_id_oh : '0;
  always_comb begin
    w_win = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) if (w_cand[k]) w_win = ID_W'(k);
  end
  // a fresh edge is ORed in after the ack clear, so a coincident event survives
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_pend  <= '0;
      r_cause <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_edge;
      case (r_state)
        IDLE: if (|w_cand) begin
          r_id    <= w_win;
          r_cause <= IRQ_CAUSE_INT | 32'(IRQ_CAUSE_BASE + int'(w_win));
          r_state <= REQ;
        end
        REQ: if (irq_ack_i) r_state <= SERVICE;
             else if (~|(mie_i & w_id_oh)) r_state <= IDLE;
        SERVICE: if (irq_ret_i) r_state <= RET;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign irq_o         = r_state == REQ;
  assign irq_ret_o     = r_state == RET ? w_id_oh : '0;
  assign irq_cause_o   = r_cause;
  assign irq_pending_o = r_pend;
endmodule
